key_scheduler: RTL and testbench
================================

Name: key_scheduler

Overview:
- Time-multiplexes the single keycode mapper between player 1 and player 2 once per video frame.
- Drives the mapper's player-select input and captures each player's mapped keycode.
- Decodes captures into compact action codes, applies press-edge and cooldown rules to attacks, then publishes both players' actions to the fighter state machines with a one-cycle valid strobe.
- Sits between the USB keycode/mapper path and the per-fighter motion/animation FSMs.

Parameters:
- SETTLE, 1, cycles pno is held before each capture (mapper path settle time); legal range 1..15
- ATTACK_COOLDOWN, 8, frames an accepted PUNCH/KICK blocks further attacks for that player; 0 disables cooldown

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  single-cycle pulse, once per frame, synchronous to Clk
- game_mode  in  3  3'b001 single player, 3'b010 two player, others idle/menu
- mapped_keycode  in  8  mapper output for the currently selected player
- pno  out  1  player select to mapper; 0 = P1, 1 = P2
- p1_action  out  3  published P1 action (action_t)
- p2_action  out  3  published P2 action (action_t)
- p1_new  out  1  P1 action changed to a non-NONE value this publish
- p2_new  out  1  P2 action changed to a non-NONE value this publish
- actions_valid  out  1  one-cycle strobe; action outputs updated this cycle
- overrun  out  1  sticky: frame_tick arrived while a tick was already pending

Behaviour:
- Reset: pno=0, p1_action=p2_action=NONE, p1_new=p2_new=0, actions_valid=0, overrun=0, both cooldowns=0, both prev-raw=NONE, pending=0, state=IDLE. Reset mid-sequence abandons the sequence; nothing is published.
- Decode (mapped_keycode -> action_t): 8'h1A JUMP, 8'h16 CROUCH, 8'h07 RIGHT, 8'h04 LEFT, 8'h0E PUNCH, 8'h13 KICK. Any other value, including 8'h00, decodes to NONE.
- FSM states: IDLE, SEL_P1, CAP_P1, SEL_P2, CAP_P2, PUBLISH.
- IDLE: a frame_tick or pending=1 moves to SEL_P1, clears pending, and latches game_mode into mode_q. mode_q is used for the whole sequence.
- SEL_P1: pno=0, held SETTLE cycles, then CAP_P1.
- CAP_P1: capture decoded value into raw1.
  - mode_q=010: go to SEL_P2.
  - otherwise: raw2=NONE, go to PUBLISH.
- SEL_P2: pno=1, held SETTLE cycles, then CAP_P2.
- CAP_P2: capture into raw2, pno returns to 0, go to PUBLISH.
- mode_q not 001 or 010: raw1=raw2=NONE, and the P2 states are skipped.
- PUBLISH (exactly one cycle): actions_valid=1 and action outputs take their new values in this cycle; next state IDLE.
- Timing: with the tick sampled at cycle t, PUBLISH occurs at t+2*SETTLE+3 in two-player mode and t+SETTLE+2 otherwise. With SETTLE=1 that is t+5 and t+3.
- frame_tick outside IDLE sets pending. A tick while pending=1 also sets overrun, which stays set until Reset. Pending ticks coalesce; at most one extra sequence runs.
- Per-player attack gating at PUBLISH (x = 1, 2):
  - raw_x is PUNCH or KICK, raw_x != prev_raw_x, and cd_x==0: publish raw_x and load cd_x=ATTACK_COOLDOWN.
  - raw_x is PUNCH or KICK, otherwise: publish NONE (held key or cooling down).
  - raw_x not an attack: publish raw_x unchanged (movement is level-sensitive).
  - After gating, prev_raw_x <= raw_x.
  - If not loaded, cd_x decrements by 1 per PUBLISH, saturating at 0. A load takes priority over the decrement.
- px_new=1 in PUBLISH iff the new published action != the previous published action and the new action != NONE. px_new is 0 in all other cycles.
- Action outputs hold their value between publishes.

Decomposition:
- Package key_sched_pkg holds:
  - action_t enum (3 bits): NONE=0, JUMP=1, CROUCH=2, RIGHT=3, LEFT=4, PUNCH=5, KICK=6
  - game-mode constants MODE_SINGLE=3'b001, MODE_VERSUS=3'b010
  - the six keycode constants
  - sched_state_t
- One sub-module, attack_gate, instantiated once per player: raw, prev_raw, cooldown counter -> gated action and new flag.

Test Plan:
- Reset, then mode 010, P1 mapped 8'h07, P2 mapped 8'h04, one tick at cycle t -> pno=0 in t+1, pno=1 in t+3, actions_valid only in t+5, p1_action=RIGHT, p2_action=LEFT, p1_new=p2_new=1.
- Mode 001, mapped 8'h1A -> PUBLISH at t+3, pno never 1, p1_action=JUMP, p2_action=NONE.
- Mode 010, P1 holds 8'h0E for 12 frames, ATTACK_COOLDOWN=8 -> PUNCH on frame 1 only, NONE on frames 2-12. Release then re-press at frame 5 -> NONE. Re-press at frame 10 (cooldown expired) -> PUNCH.
- Mode 010, P2 mapped 8'h55 (unmapped) and mode 3'b100 -> action NONE, px_new=0.
- Two ticks 2 cycles apart (both mid-sequence), then a third tick while pending -> second sequence starts immediately after the first PUBLISH, overrun=1 and stays set, exactly 2 actions_valid pulses.
- Reset asserted in SEL_P2 -> next cycle state IDLE, pno=0, outputs NONE, no actions_valid; a later tick runs a normal sequence.

Source files
------------

// File: rtl/key_sched_pkg.sv
// Shared types and constants for the per-frame keycode scheduler.
// Holds action codes, game modes, keycodes, FSM state encoding and decode helper.
package key_sched_pkg;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_JUMP   = 3'd1,
        ACT_CROUCH = 3'd2,
        ACT_RIGHT  = 3'd3,
        ACT_LEFT   = 3'd4,
        ACT_PUNCH  = 3'd5,
        ACT_KICK   = 3'd6
    } action_t;

    localparam logic [2:0] MODE_SINGLE = 3'b001;
    localparam logic [2:0] MODE_VERSUS = 3'b010;

    localparam logic [7:0] KEY_JUMP   = 8'h1A;
    localparam logic [7:0] KEY_CROUCH = 8'h16;
    localparam logic [7:0] KEY_RIGHT  = 8'h07;
    localparam logic [7:0] KEY_LEFT   = 8'h04;
    localparam logic [7:0] KEY_PUNCH  = 8'h0E;
    localparam logic [7:0] KEY_KICK   = 8'h13;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t S_IDLE    = 3'd0;
    localparam sched_state_t S_SEL_P1  = 3'd1;
    localparam sched_state_t S_CAP_P1  = 3'd2;
    localparam sched_state_t S_SEL_P2  = 3'd3;
    localparam sched_state_t S_CAP_P2  = 3'd4;
    localparam sched_state_t S_PUBLISH = 3'd5;

    function automatic action_t decode_key(input logic [7:0] key);
        action_t a;
        a = ACT_NONE;
        unique case (1'b1)
            (key == KEY_JUMP):   a = ACT_JUMP;
            (key == KEY_CROUCH): a = ACT_CROUCH;
            (key == KEY_RIGHT):  a = ACT_RIGHT;
            (key == KEY_LEFT):   a = ACT_LEFT;
            (key == KEY_PUNCH):  a = ACT_PUNCH;
            (key == KEY_KICK):   a = ACT_KICK;
            default:             a = ACT_NONE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/key_scheduler_attack_gate.sv
// Per-player attack gate: press-edge and cooldown filter on PUNCH/KICK.
// Ports: Clk, Reset, publish_i, raw_i -> action_o (published), new_o (change strobe).
module attack_gate
    import key_sched_pkg::*;
#(
    parameter int unsigned ATTACK_COOLDOWN = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       publish_i,
    input  logic [2:0] raw_i,
    output logic [2:0] action_o,
    output logic       new_o
);

    localparam logic [7:0] CD_LOAD = 8'(ATTACK_COOLDOWN);

    action_t    raw;
    action_t    act_q;
    action_t    prev_q;
    logic [7:0] cd_q;
    logic       is_atk;
    logic       accept;
    action_t    gated;

    assign raw    = action_t'(raw_i);
    assign is_atk = (raw == ACT_PUNCH) || (raw == ACT_KICK);
    assign accept = is_atk && (raw != prev_q) && (cd_q == 8'd0);
    assign gated  = (is_atk && !accept) ? ACT_NONE : raw;

    // The new value is visible during the publish cycle itself.
    assign action_o = publish_i ? gated : act_q;
    assign new_o    = publish_i && (gated != act_q) && (gated != ACT_NONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            act_q  <= ACT_NONE;
            prev_q <= ACT_NONE;
            cd_q   <= 8'd0;
        end else if (publish_i) begin
            act_q  <= gated;
            prev_q <= raw;
            if (accept)
                cd_q <= CD_LOAD;
            else if (cd_q != 8'd0)
                cd_q <= cd_q - 8'd1;
        end
    end

endmodule

// File: rtl/key_scheduler.sv
// Time-multiplexes the keycode mapper between two players once per frame.
// Ports: Clk, Reset, frame_tick, game_mode, mapped_keycode -> pno, pX_action, pX_new, actions_valid, overrun.
module key_scheduler
    import key_sched_pkg::*;
#(
    parameter int unsigned SETTLE          = 1,
    parameter int unsigned ATTACK_COOLDOWN = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [2:0] game_mode,
    input  logic [7:0] mapped_keycode,
    output logic       pno,
    output logic [2:0] p1_action,
    output logic [2:0] p2_action,
    output logic       p1_new,
    output logic       p2_new,
    output logic       actions_valid,
    output logic       overrun
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    sched_state_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [2:0]   mode_q, mode_d;
    logic         pending_q, pending_d;
    logic         overrun_q, overrun_d;
    logic         pno_q, pno_d;
    action_t      raw1_q, raw1_d;
    action_t      raw2_q, raw2_d;
    logic         publish;
    logic         mode_ok;

    assign publish = (state_q == S_PUBLISH);
    assign mode_ok = (mode_q == MODE_SINGLE) || (mode_q == MODE_VERSUS);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        pno_d     = pno_q;
        raw1_d    = raw1_q;
        raw2_d    = raw2_q;

        // Ticks arriving mid-sequence coalesce into one pending run.
        if (frame_tick && state_q != S_IDLE) begin
            pending_d = 1'b1;
            if (pending_q)
                overrun_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (frame_tick || pending_q) begin
                    state_d   = S_SEL_P1;
                    pending_d = 1'b0;
                    mode_d    = game_mode;
                    cnt_d     = 4'd0;
                end
            end
            S_SEL_P1: begin
                if (cnt_q == SETTLE_LAST)
                    state_d = S_CAP_P1;
                else
                    cnt_d = cnt_q + 4'd1;
            end
            S_CAP_P1: begin
                raw1_d = mode_ok ? decode_key(mapped_keycode) : ACT_NONE;
                if (mode_q == MODE_VERSUS) begin
                    state_d = S_SEL_P2;
                    cnt_d   = 4'd0;
                    pno_d   = 1'b1;
                end else begin
                    raw2_d  = ACT_NONE;
                    state_d = S_PUBLISH;
                end
            end
            S_SEL_P2: begin
                if (cnt_q == SETTLE_LAST)
                    state_d = S_CAP_P2;
                else
                    cnt_d = cnt_q + 4'd1;
            end
            S_CAP_P2: begin
                raw2_d  = decode_key(mapped_keycode);
                pno_d   = 1'b0;
                state_d = S_PUBLISH;
            end
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            mode_q    <= 3'd0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            pno_q     <= 1'b0;
            raw1_q    <= ACT_NONE;
            raw2_q    <= ACT_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            pno_q     <= pno_d;
            raw1_q    <= raw1_d;
            raw2_q    <= raw2_d;
        end
    end

    attack_gate #(.ATTACK_COOLDOWN(ATTACK_COOLDOWN)) u_gate_p1 (
        .Clk       (Clk),
        .Reset     (Reset),
        .publish_i (publish),
        .raw_i     (raw1_q),
        .action_o  (p1_action),
        .new_o     (p1_new)
    );

    attack_gate #(.ATTACK_COOLDOWN(ATTACK_COOLDOWN)) u_gate_p2 (
        .Clk       (Clk),
        .Reset     (Reset),
        .publish_i (publish),
        .raw_i     (raw2_q),
        .action_o  (p2_action),
        .new_o     (p2_new)
    );

    assign pno           = pno_q;
    assign actions_valid = publish;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_key_scheduler.sv
// Directed bench for key_scheduler: vector table plus multi-cycle sequences.
// Mapper is modelled as a mux of two per-player keycodes on pno.
module tb_key_scheduler;
    import key_sched_pkg::*;

    logic       Clk;
    logic       Reset;
    logic       frame_tick;
    logic [2:0] game_mode;
    logic [7:0] mapped_keycode;
    logic       pno;
    logic [2:0] p1_action;
    logic [2:0] p2_action;
    logic       p1_new;
    logic       p2_new;
    logic       actions_valid;
    logic       overrun;

    logic [7:0] k1;
    logic [7:0] k2;

    int checks;
    int failures;

    assign mapped_keycode = pno ? k2 : k1;

    key_scheduler #(.SETTLE(1), .ATTACK_COOLDOWN(8)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_tick     (frame_tick),
        .game_mode      (game_mode),
        .mapped_keycode (mapped_keycode),
        .pno            (pno),
        .p1_action      (p1_action),
        .p2_action      (p2_action),
        .p1_new         (p1_new),
        .p2_new         (p2_new),
        .actions_valid  (actions_valid),
        .overrun        (overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] k1;
        logic [7:0] k2;
        logic [2:0] e1;
        logic [2:0] e2;
        logic       en1;
        logic       en2;
        int         lat;
        logic [31:0] pno_mask;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Tick sampled at the edge ending cycle 0; cycle k is observed at negedge k.
    task automatic run_frame(
        input  logic [2:0] mode,
        input  logic [7:0] kv1,
        input  logic [7:0] kv2,
        output int         lat,
        output logic [2:0] a1,
        output logic [2:0] a2,
        output logic       n1,
        output logic       n2,
        output logic [31:0] pno_seen
    );
        lat      = 0;
        a1       = 3'd7;
        a2       = 3'd7;
        n1       = 1'b0;
        n2       = 1'b0;
        pno_seen = 32'd0;
        @(negedge Clk);
        game_mode  = mode;
        k1         = kv1;
        k2         = kv2;
        frame_tick = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            frame_tick = 1'b0;
            if (pno)
                pno_seen[k] = 1'b1;
            if (actions_valid) begin
                lat = k;
                a1  = p1_action;
                a2  = p2_action;
                n1  = p1_new;
                n2  = p2_new;
                break;
            end
        end
        if (lat == 0)
            check("publish_timeout", 0, 1);
    endtask

    int          lat;
    logic [2:0]  a1, a2;
    logic        n1, n2;
    logic [31:0] pseen;
    int          pulses;
    int          first_k;
    int          second_k;

    initial begin
        checks     = 0;
        failures   = 0;
        Reset      = 1'b1;
        frame_tick = 1'b0;
        game_mode  = 3'b000;
        k1         = 8'h00;
        k2         = 8'h00;

        vecs[0] = '{3'b010, 8'h07, 8'h04, ACT_RIGHT,  ACT_LEFT,  1'b1, 1'b1, 5, 32'h18};
        vecs[1] = '{3'b010, 8'h07, 8'h04, ACT_RIGHT,  ACT_LEFT,  1'b0, 1'b0, 5, 32'h18};
        vecs[2] = '{3'b001, 8'h1A, 8'h04, ACT_JUMP,   ACT_NONE,  1'b1, 1'b0, 3, 32'h00};
        vecs[3] = '{3'b010, 8'h16, 8'h1A, ACT_CROUCH, ACT_JUMP,  1'b1, 1'b1, 5, 32'h18};
        vecs[4] = '{3'b010, 8'h0E, 8'h13, ACT_PUNCH,  ACT_KICK,  1'b1, 1'b1, 5, 32'h18};
        vecs[5] = '{3'b010, 8'h0E, 8'h13, ACT_NONE,   ACT_NONE,  1'b0, 1'b0, 5, 32'h18};
        vecs[6] = '{3'b010, 8'h55, 8'h00, ACT_NONE,   ACT_NONE,  1'b0, 1'b0, 5, 32'h18};
        vecs[7] = '{3'b100, 8'h07, 8'h04, ACT_NONE,   ACT_NONE,  1'b0, 1'b0, 3, 32'h00};
        vecs[8] = '{3'b010, 8'h04, 8'h07, ACT_LEFT,   ACT_RIGHT, 1'b1, 1'b1, 5, 32'h18};

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_pno",     pno,           0);
        check("rst_p1",      p1_action,     ACT_NONE);
        check("rst_p2",      p2_action,     ACT_NONE);
        check("rst_p1_new",  p1_new,        0);
        check("rst_p2_new",  p2_new,        0);
        check("rst_valid",   actions_valid, 0);
        check("rst_overrun", overrun,       0);

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i].mode, vecs[i].k1, vecs[i].k2, lat, a1, a2, n1, n2, pseen);
            check($sformatf("v%0d_lat", i),  lat,   vecs[i].lat);
            check($sformatf("v%0d_p1", i),   a1,    vecs[i].e1);
            check($sformatf("v%0d_p2", i),   a2,    vecs[i].e2);
            check($sformatf("v%0d_n1", i),   n1,    vecs[i].en1);
            check($sformatf("v%0d_n2", i),   n2,    vecs[i].en2);
            check($sformatf("v%0d_pno", i),  pseen, vecs[i].pno_mask);
            @(negedge Clk);
            check($sformatf("v%0d_hold1", i), p1_action,     vecs[i].e1);
            check($sformatf("v%0d_hold2", i), p2_action,     vecs[i].e2);
            check($sformatf("v%0d_vlow", i),  actions_valid, 0);
            check($sformatf("v%0d_nlow", i),  p1_new,        0);
        end

        // Held punch: accepted on the first frame only.
        do_reset();
        for (int f = 1; f <= 12; f++) begin
            run_frame(3'b010, 8'h0E, 8'h00, lat, a1, a2, n1, n2, pseen);
            check($sformatf("hold_f%0d_p1", f), a1, (f == 1) ? ACT_PUNCH : ACT_NONE);
            check($sformatf("hold_f%0d_n1", f), n1, (f == 1) ? 1 : 0);
            check($sformatf("hold_f%0d_p2", f), a2, ACT_NONE);
        end

        // Re-press during cooldown is dropped; after expiry it is accepted.
        do_reset();
        for (int f = 1; f <= 10; f++) begin
            run_frame(3'b010,
                      (f == 1 || f == 5 || f == 10) ? 8'h0E : 8'h00,
                      8'h00, lat, a1, a2, n1, n2, pseen);
            check($sformatf("rep_f%0d_p1", f), a1,
                  (f == 1 || f == 10) ? ACT_PUNCH : ACT_NONE);
            check($sformatf("rep_f%0d_n1", f), n1,
                  (f == 1 || f == 10) ? 1 : 0);
        end

        // Three ticks: two coalesce into one extra run, third flags overrun.
        do_reset();
        pulses   = 0;
        first_k  = 0;
        second_k = 0;
        @(negedge Clk);
        game_mode  = 3'b010;
        k1         = 8'h07;
        k2         = 8'h04;
        frame_tick = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clk);
            frame_tick = (k == 2 || k == 4);
            if (k == 3)
                check("ovr_before", overrun, 0);
            if (actions_valid) begin
                pulses++;
                if (pulses == 1)
                    first_k = k;
                else if (pulses == 2)
                    second_k = k;
            end
        end
        check("ovr_pulses",   pulses,   2);
        check("ovr_first_k",  first_k,  5);
        check("ovr_second_k", second_k, 11);
        check("ovr_set",      overrun,  1);
        run_frame(3'b010, 8'h07, 8'h04, lat, a1, a2, n1, n2, pseen);
        check("ovr_sticky",   overrun,  1);
        check("ovr_lat",      lat,      5);

        // Reset landing in SEL_P2 abandons the sequence.
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("mid_selp2_pno", pno, 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("mid_rst_pno",   pno,           0);
        check("mid_rst_p1",    p1_action,     ACT_NONE);
        check("mid_rst_p2",    p2_action,     ACT_NONE);
        check("mid_rst_valid", actions_valid, 0);
        check("mid_rst_ovr",   overrun,       0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (actions_valid)
                pulses++;
        end
        check("mid_no_pub", pulses, 0);
        run_frame(3'b010, 8'h07, 8'h04, lat, a1, a2, n1, n2, pseen);
        check("post_lat", lat, 5);
        check("post_p1",  a1,  ACT_RIGHT);
        check("post_p2",  a2,  ACT_LEFT);
        check("post_n1",  n1,  1);
        check("post_n2",  n2,  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
